// File: rtl/uart_pkg.sv
// Shared types and framing constants for the uart_io byte engine.
package uart_pkg;

    typedef enum logic [1:0] {CTL_IDLE, CTL_TX, CTL_RX_WAIT} ctl_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with an extra pointer bit for full/empty; push and pop in one cycle both
// take effect, and a pop from an empty FIFO with a simultaneous push passes push_data through.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push  = push && (!full || pop);
        do_pop   = pop && (!empty || push);
        pop_data = empty ? push_data : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_io.sv
// uart_io: 8N1 byte UART engine serving the IO proxy's ready/t_valid/r_valid handshake.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry rx FIFO; otherwise a single holding register.
module uart_io
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       ready,
    input  logic       t_valid,
    input  logic [7:0] t_data,
    input  logic       r_valid,
    output logic [7:0] r_data,
    output logic       tx_done,
    output logic       rx_done,
    output logic       rx_overrun,
    input  logic       rxd,
    output logic       txd
);
    localparam int unsigned   CW       = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (CLK_PER_BIT < 4 || CLK_PER_BIT > 65535 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_io: illegal CLK_PER_BIT or FIFO_DEPTH");
    end

    ctl_state_t    ctl_state;
    tx_state_t     tx_state;
    rx_state_t     rx_state;
    logic          take_tx, take_rx, rx_pop, rx_push;
    logic          buf_empty, buf_full;
    logic [7:0]    buf_data;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_shift, rx_shift;
    logic          rxd_s1, rxd_s2, rxd_prev;

    // A read that finds a byte already buffered pops in the request cycle and stays idle.
    always_comb begin
        take_tx = (ctl_state == CTL_IDLE) && ready && t_valid;
        take_rx = (ctl_state == CTL_IDLE) && ready && r_valid && !t_valid;
        rx_pop  = (take_rx || ctl_state == CTL_RX_WAIT) && !buf_empty;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctl_state  <= CTL_IDLE;
            ready      <= 1'b0;
            r_data     <= '0;
            rx_done    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (rx_pop) begin
                r_data  <= buf_data;
                rx_done <= 1'b1;
            end
            if (rx_push && buf_full && !rx_pop) rx_overrun <= 1'b1;
            unique case (ctl_state)
                CTL_IDLE: begin
                    ready <= 1'b1;
                    if (take_tx) begin
                        ctl_state <= CTL_TX;
                        ready     <= 1'b0;
                    end else if (take_rx && buf_empty) begin
                        ctl_state <= CTL_RX_WAIT;
                        ready     <= 1'b0;
                    end
                end
                CTL_TX: if (tx_done) begin
                    ctl_state <= CTL_IDLE;
                    ready     <= 1'b1;
                end
                CTL_RX_WAIT: if (!buf_empty) begin
                    ctl_state <= CTL_IDLE;
                    ready     <= 1'b1;
                end
                default: begin
                    ctl_state <= CTL_IDLE;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            txd      <= STOP_BIT;
            tx_done  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_done <= 1'b0;
            unique case (tx_state)
                TX_IDLE: if (take_tx) begin
                    txd      <= START_BIT;
                    tx_shift <= t_data;
                    tx_cnt   <= FULL_BIT;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_cnt == '0) begin
                    txd      <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= '0;
                    tx_cnt   <= FULL_BIT;
                    tx_state <= TX_DATA;
                end else tx_cnt <= tx_cnt - CW'(1);
                TX_DATA: if (tx_cnt == '0) begin
                    tx_cnt <= FULL_BIT;
                    if (tx_bit == LAST_BIT) begin
                        txd      <= STOP_BIT;
                        tx_state <= TX_STOP;
                    end else begin
                        txd      <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else tx_cnt <= tx_cnt - CW'(1);
                TX_STOP: if (tx_cnt == '0) begin
                    tx_done  <= 1'b1;
                    tx_state <= TX_IDLE;
                end else tx_cnt <= tx_cnt - CW'(1);
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign rx_push = (rx_state == RX_STOP) && (rx_cnt == '0) && (rxd_s2 == STOP_BIT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            unique case (rx_state)
                RX_IDLE: if (rxd_prev && !rxd_s2) begin
                    rx_cnt   <= HALF_BIT;
                    rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == '0) begin
                    if (rxd_s2 == START_BIT) begin
                        rx_cnt   <= FULL_BIT;
                        rx_bit   <= '0;
                        rx_state <= RX_DATA;
                    end else rx_state <= RX_IDLE;
                end else rx_cnt <= rx_cnt - CW'(1);
                RX_DATA: if (rx_cnt == '0) begin
                    rx_shift <= {rxd_s2, rx_shift[7:1]};
                    rx_cnt   <= FULL_BIT;
                    if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
                    else rx_bit <= rx_bit + 3'd1;
                end else rx_cnt <= rx_cnt - CW'(1);
                RX_STOP: if (rx_cnt == '0) rx_state <= RX_IDLE;
                else rx_cnt <= rx_cnt - CW'(1);
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_BITS)
    ) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (rx_push),
        .push_data(rx_shift),
        .pop      (rx_pop),
        .pop_data (buf_data),
        .empty    (buf_empty),
        .full     (buf_full)
    );
`else
    logic [7:0] hold_data;
    logic       hold_full;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (rx_push && (!hold_full || rx_pop)) begin
            hold_data <= rx_shift;
            hold_full <= 1'b1;
        end else if (rx_pop) begin
            hold_full <= 1'b0;
        end
    end

    assign buf_data  = hold_data;
    assign buf_empty = !hold_full;
    assign buf_full  = hold_full;
`endif

endmodule
